// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM fade controller.
//   DUTY_W_DEF  : default width of the duty value sent to the PWM peripheral
//   DWELL_W_DEF : default width of the per-step dwell counter
//   fade_state_e: controller state encoding
package pwm_ctrl_pkg;

    localparam int DUTY_W_DEF  = 8;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } fade_state_e;

endpackage

// File: rtl/pwm_dwell_timer.sv
// Dwell timer for the fade controller: counts enabled cycles from zero and
// flags when the count equals the programmed limit.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force the count to zero on the next edge (wins over enable)
//   enable   : advance the count by one on the next edge
//   limit    : unsigned compare value
//   match    : count currently equals limit
module pwm_dwell_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [DWELL_W-1:0] limit,
    output logic               match
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match = (cnt_q == limit);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM fade controller: accepts a fade request (target, step, dwell) and walks
// the registered duty value toward the target one step at a time, holding
// each level for dwell+2 cycles, then pulses done.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cfg_valid   : request presented;  cfg_ready : controller idle, can accept
//   cfg_target  : final duty;  cfg_step : increment (0 = jump);  cfg_dwell : hold cycles
//   pause       : freezes the dwell timer;  abort : cancel active fade
//   duty_cycle  : registered duty for the PWM peripheral
//   busy        : not idle;  done : one-cycle pulse when target is reached
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DUTY_W-1:0]  cfg_target,
    input  logic [DUTY_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               pause,
    input  logic               abort,
    output logic [DUTY_W-1:0]  duty_cycle,
    output logic               busy,
    output logic               done
);

    fade_state_e        state_q, state_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [DUTY_W-1:0]  tgt_q, tgt_d;
    logic [DUTY_W-1:0]  step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               accept;
    logic               dwell_match;

    // One step from cur toward tgt, clamped at tgt. The extra top bit of the
    // intermediates catches both overflow past the maximum and underflow
    // below zero, so the result can never wrap.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] stp
    );
        logic [DUTY_W:0] up;
        logic [DUTY_W:0] dn;
        up = {1'b0, cur} + {1'b0, stp};
        dn = {1'b0, cur} - {1'b0, stp};
        if (stp == '0) begin
            return tgt;
        end else if (cur < tgt) begin
            return (up >= {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
        end else begin
            return (dn[DUTY_W] || (dn <= {1'b0, tgt})) ? tgt : dn[DUTY_W-1:0];
        end
    endfunction

    // Timer is held at zero outside DWELL, so every entry into DWELL starts
    // counting from 0 without a separate clear pulse.
    pwm_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_DWELL),
        .enable (!pause),
        .limit  (dwell_q),
        .match  (dwell_match)
    );

    // abort outranks acceptance even though cfg_ready stays high in IDLE
    assign accept = cfg_valid && (state_q == ST_IDLE) && !abort;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tgt_d   = cfg_target;
                    step_d  = cfg_step;
                    dwell_d = cfg_dwell;
                    state_d = (cfg_target == duty_q) ? ST_DONE : ST_DWELL;
                end
            end
            ST_DWELL: begin
                // pause also blocks the exit so each paused cycle adds exactly one
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause && dwell_match) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    duty_d  = step_toward(duty_q, tgt_q, step_q);
                    state_d = (duty_d == tgt_q) ? ST_DONE : ST_DWELL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
        end
    end

    assign cfg_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    // an abort during the DONE cycle cancels the completion pulse
    assign done       = (state_q == ST_DONE) && !abort;
    assign duty_cycle = duty_q;

endmodule
